// File: rtl/dcache_mem_ctrl.sv
// rtl/dcache_mem_ctrl.sv - block miss engine moving one cache block over a byte-wide RAM port
module dcache_mem_ctrl #(
    parameter int BLOCK_WIDTH = 4,
    localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH
) (
    input  logic                      clkIn,
    input  logic                      resetIn,
    input  logic                      clearIn,
    input  logic                      missIn,
    input  logic [31:BLOCK_WIDTH]     missAddrIn,
    input  logic                      readWriteIn,
    input  logic [BLOCK_SIZE*8-1:0]   writeBackIn,
    output logic                      memDataValid,
    output logic [31:BLOCK_WIDTH]     memAddr,
    output logic [BLOCK_SIZE*8-1:0]   memDataOut,
    output logic                      acceptWrite,
    output logic                      busy,
    input  logic [7:0]                ramDataIn,
    output logic [7:0]                ramDataOut,
    output logic [31:0]               ramAddrOut,
    output logic                      ramWriteOut
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, COOL} state_t;

    localparam logic [BLOCK_WIDTH:0] CNT_ONE     = (BLOCK_WIDTH+1)'(1);
    localparam logic [BLOCK_WIDTH:0] CNT_LAST_WR = (BLOCK_WIDTH+1)'(BLOCK_SIZE - 1);
    localparam logic [BLOCK_WIDTH:0] CNT_LAST_RD = (BLOCK_WIDTH+1)'(BLOCK_SIZE);

    state_t                    state;
    logic [31:BLOCK_WIDTH]     addrReg;
    logic [BLOCK_SIZE*8-1:0]   wbData;
    logic [BLOCK_WIDTH:0]      cnt;
    logic [BLOCK_WIDTH:0]      cntNext;
    logic [BLOCK_WIDTH-1:0]    nextIdx;
    logic [BLOCK_WIDTH-1:0]    prevIdx;

    assign cntNext = cnt + CNT_ONE;
    assign nextIdx = cntNext[BLOCK_WIDTH-1:0];
    // RAM data lags its address by one cycle, so cycle c delivers byte c-1
    assign prevIdx = cnt[BLOCK_WIDTH-1:0] - BLOCK_WIDTH'(1);

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state        <= IDLE;
            addrReg      <= '0;
            wbData       <= '0;
            cnt          <= '0;
            memDataValid <= 1'b0;
            acceptWrite  <= 1'b0;
            busy         <= 1'b0;
            memAddr      <= '0;
            memDataOut   <= '0;
            ramDataOut   <= '0;
            ramAddrOut   <= '0;
            ramWriteOut  <= 1'b0;
        end else begin
            memDataValid <= 1'b0;
            acceptWrite  <= 1'b0;
            case (state)
                IDLE: begin
                    if (missIn && !clearIn) begin
                        addrReg    <= missAddrIn;
                        wbData     <= writeBackIn;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        ramAddrOut <= {missAddrIn, {BLOCK_WIDTH{1'b0}}};
                        if (readWriteIn) begin
                            state       <= READ;
                            ramWriteOut <= 1'b0;
                        end else begin
                            state       <= WRITE;
                            ramWriteOut <= 1'b1;
                            ramDataOut  <= writeBackIn[7:0];
                        end
                    end
                end
                READ: begin
                    if (clearIn) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        ramAddrOut <= '0;
                    end else begin
                        if (cnt != '0)
                            memDataOut[{prevIdx, 3'b000} +: 8] <= ramDataIn;
                        if (cnt == CNT_LAST_RD) begin
                            state        <= COOL;
                            memDataValid <= 1'b1;
                            memAddr      <= addrReg;
                        end else begin
                            cnt        <= cntNext;
                            ramAddrOut <= (cntNext == CNT_LAST_RD) ? '0 : {addrReg, nextIdx};
                        end
                    end
                end
                WRITE: begin
                    if (cnt == CNT_LAST_WR) begin
                        state       <= COOL;
                        acceptWrite <= 1'b1;
                        memAddr     <= addrReg;
                        ramWriteOut <= 1'b0;
                        ramAddrOut  <= '0;
                        ramDataOut  <= '0;
                    end else begin
                        cnt        <= cntNext;
                        ramAddrOut <= {addrReg, nextIdx};
                        ramDataOut <= wbData[{nextIdx, 3'b000} +: 8];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
